// File: rtl/gpio_cfg_chain_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_cfg_chain_ctrl_if : config-bank and pad-chain signals of the master   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface gpio_cfg_chain_ctrl_if #(
  parameter int PAD_CNT   = 9,
  parameter int CFG_BITS  = 16,
  parameter int CLK_DIV_W = 4
);
  localparam int ADDR_W = (PAD_CNT > 1) ? $clog2(PAD_CNT) : 1;

  logic                 cfg_wr_en;
  logic [ADDR_W-1:0]    cfg_wr_addr;
  logic [CFG_BITS-1:0]  cfg_wr_data;
  logic [ADDR_W-1:0]    cfg_rd_addr;
  logic [CFG_BITS-1:0]  cfg_rd_data;
  logic                 start;
  logic                 verify_en;
  logic [CLK_DIV_W-1:0] clk_div;
  logic                 busy;
  logic                 done;
  logic                 chk_err;
  logic                 serial_clock;
  logic                 serial_load;
  logic                 serial_data;
  logic                 serial_data_ret;

  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_addr,
    input  start, verify_en, clk_div, serial_data_ret,
    output cfg_rd_data, busy, done, chk_err,
    output serial_clock, serial_load, serial_data
  );

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_addr,
    output start, verify_en, clk_div, serial_data_ret,
    input  cfg_rd_data, busy, done, chk_err,
    input  serial_clock, serial_load, serial_data
  );
endinterface
`default_nettype wire

// File: rtl/gpio_cfg_chain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpio_cfg_chain_ctrl : pad-config chain master (shift, optional verify,    |
// | load). Rev 1.0                                                             |
// +----------------------------------------------------------------------------+
module gpio_cfg_chain_ctrl #(
  parameter int                  PAD_CNT     = 9,
  parameter int                  CFG_BITS    = 16,
  parameter int                  CLK_DIV_W   = 4,
  parameter logic [CFG_BITS-1:0] DEFAULT_CFG = 16'h3000
) (
  input  wire logic            mclk,
  input  wire logic            reset,
  gpio_cfg_chain_ctrl_if.slave bus
);
  localparam int               ADDR_W   = (PAD_CNT > 1) ? $clog2(PAD_CNT) : 1;
  localparam int               TOTAL    = PAD_CNT * CFG_BITS;
  localparam int               BIT_W    = $clog2(TOTAL + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [CFG_BITS-1:0]  cfg_q [PAD_CNT];
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [CLK_DIV_W-1:0] ph_q;
  logic [CLK_DIV_W-1:0] div_q;
  logic                 verify_q;
  logic                 pass2_q;
  logic                 hi_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 chk_err_q;
  logic                 sclk_q;
  logic                 sload_q;
  logic                 sdata_q;

  logic [TOTAL-1:0]     img_d;
  logic [CFG_BITS-1:0]  rd_data_d;
  logic [BIT_W-1:0]     nxt_idx_d;
  logic                 first_bit_d;
  logic                 next_bit_d;

  // Word i occupies img_d[i*CFG_BITS +: CFG_BITS]; the MSB end is shifted first.
  for (genvar i = 0; i < PAD_CNT; i++) begin : g_img
    assign img_d[i*CFG_BITS +: CFG_BITS] = cfg_q[i];
  end

  assign nxt_idx_d   = LAST_BIT - bit_cnt_q - 1'b1;
  assign first_bit_d = img_d[TOTAL-1];
  assign next_bit_d  = img_d[nxt_idx_d];

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < PAD_CNT; i++) begin
      if (bus.cfg_rd_addr == ADDR_W'(i)) rd_data_d = cfg_q[i];
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PAD_CNT; i++) cfg_q[i] <= DEFAULT_CFG;
    end else if (bus.cfg_wr_en && !busy_q) begin
      for (int i = 0; i < PAD_CNT; i++) begin
        if (bus.cfg_wr_addr == ADDR_W'(i)) cfg_q[i] <= bus.cfg_wr_data;
      end
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      ph_q      <= '0;
      div_q     <= '0;
      verify_q  <= 1'b0;
      pass2_q   <= 1'b0;
      hi_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      chk_err_q <= 1'b0;
      sclk_q    <= 1'b0;
      sload_q   <= 1'b0;
      sdata_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_SHIFT;
            busy_q    <= 1'b1;
            div_q     <= bus.clk_div;
            ph_q      <= bus.clk_div;
            verify_q  <= bus.verify_en;
            chk_err_q <= 1'b0;
            bit_cnt_q <= '0;
            pass2_q   <= 1'b0;
            hi_q      <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= first_bit_d;
          end
        end
        S_SHIFT: begin
          if (ph_q != '0) begin
            ph_q <= ph_q - 1'b1;
          end else begin
            ph_q <= div_q;
            if (!hi_q) begin
              hi_q   <= 1'b1;
              sclk_q <= 1'b1;
              // Last LO cycle: the chain tail presents the pass-1 copy of this bit.
              if (pass2_q && (bus.serial_data_ret != sdata_q)) chk_err_q <= 1'b1;
            end else begin
              hi_q   <= 1'b0;
              sclk_q <= 1'b0;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= '0;
                if (verify_q && !pass2_q) begin
                  pass2_q <= 1'b1;
                  sdata_q <= first_bit_d;
                end else begin
                  state_q <= S_LOAD;
                  sdata_q <= 1'b0;
                  sload_q <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                sdata_q   <= next_bit_d;
              end
            end
          end
        end
        S_LOAD: begin
          if (ph_q != '0) begin
            ph_q <= ph_q - 1'b1;
          end else begin
            sload_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cfg_rd_data  = rd_data_d;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.chk_err      = chk_err_q;
  assign bus.serial_clock = sclk_q;
  assign bus.serial_load  = sload_q;
  assign bus.serial_data  = sdata_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_cfg_chain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gpio_cfg_chain_ctrl : scoreboard bench with a behavioural pad chain     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_gpio_cfg_chain_ctrl;
  localparam int                  PAD_CNT   = 9;
  localparam int                  CFG_BITS  = 16;
  localparam int                  CLK_DIV_W = 4;
  localparam int                  TOTAL     = PAD_CNT * CFG_BITS;
  localparam logic [CFG_BITS-1:0] DEF       = 16'h3000;

  logic mclk  = 1'b0;
  logic reset = 1'b1;

  gpio_cfg_chain_ctrl_if #(.PAD_CNT(PAD_CNT), .CFG_BITS(CFG_BITS), .CLK_DIV_W(CLK_DIV_W)) bus ();

  gpio_cfg_chain_ctrl #(
    .PAD_CNT(PAD_CNT), .CFG_BITS(CFG_BITS), .CLK_DIV_W(CLK_DIV_W), .DEFAULT_CFG(DEF)
  ) dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int                                 busy_cyc;
    int                                 rises;
    int                                 load_cyc;
    logic                               chk_err;
    logic                               chk_pads;
    logic [PAD_CNT-1:0][CFG_BITS-1:0]   pads;
  } exp_t;

  exp_t                exp_q[$];
  logic [CFG_BITS-1:0] ref_cfg [PAD_CNT];
  int                  n_cmp = 0;
  int                  n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Pad chain: one flop per config bit, pad i holding chain_q[i*CFG_BITS +: CFG_BITS].
  logic [TOTAL-1:0] chain_q  = '0;
  logic             fault_en = 1'b0;
  always @(posedge bus.serial_clock) begin
    logic [TOTAL-1:0] nxt;
    nxt = {chain_q[TOTAL-2:0], bus.serial_data};
    if (fault_en) nxt[37] = 1'b1;
    chain_q <= nxt;
  end
  assign bus.serial_data_ret = chain_q[TOTAL-1];

  // Monitor: measures each update and checks it against the oldest expectation.
  int   busy_cyc = 0, rises = 0, load_cyc = 0, load_pulses = 0;
  logic prev_clk = 1'b0, prev_load = 1'b0, post_done = 1'b0;
  exp_t m_e;
  always @(negedge mclk) begin
    if (reset) begin
      busy_cyc = 0; rises = 0; load_cyc = 0; load_pulses = 0;
      prev_clk = 1'b0; prev_load = 1'b0; post_done = 1'b0;
    end else begin
      if (post_done) begin
        chk("busy_after_done", {63'd0, bus.busy}, 64'd0);
        chk("done_width", {63'd0, bus.done}, 64'd0);
        post_done = 1'b0;
      end
      if (bus.busy) busy_cyc++;
      if (bus.serial_clock && !prev_clk) rises++;
      if (bus.serial_load) load_cyc++;
      if (bus.serial_load && !prev_load) load_pulses++;
      prev_clk  = bus.serial_clock;
      prev_load = bus.serial_load;
      if (bus.done) begin
        chk("update_was_expected", {63'd0, exp_q.size() > 0}, 64'd1);
        if (exp_q.size() > 0) begin
          m_e = exp_q.pop_front();
          chk("busy_cycles", 64'(busy_cyc), 64'(m_e.busy_cyc));
          chk("sclk_rises", 64'(rises), 64'(m_e.rises));
          chk("load_cycles", 64'(load_cyc), 64'(m_e.load_cyc));
          chk("load_pulses", 64'(load_pulses), 64'd1);
          chk("chk_err_at_done", {63'd0, bus.chk_err}, {63'd0, m_e.chk_err});
          if (m_e.chk_pads) begin
            for (int i = 0; i < PAD_CNT; i++)
              chk($sformatf("pad%0d", i), 64'(chain_q[i*CFG_BITS +: CFG_BITS]), 64'(m_e.pads[i]));
          end
        end
        busy_cyc = 0; rises = 0; load_cyc = 0; load_pulses = 0;
        post_done = 1'b1;
      end
    end
  end

  task automatic do_write(input int a, input logic [CFG_BITS-1:0] data, input bit during_busy);
    @(posedge mclk); #2;
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_addr = 4'(a);
    bus.cfg_wr_data = data;
    @(posedge mclk); #2;
    bus.cfg_wr_en = 1'b0;
    if (!during_busy && a < PAD_CNT) ref_cfg[a] = data;
  endtask

  task automatic do_start(input int d, input bit ver, input bit expect_run, input bit chk_clear);
    exp_t e;
    int   npass;
    bit   any_zero;
    @(posedge mclk); #2;
    bus.start     = 1'b1;
    bus.clk_div   = CLK_DIV_W'(d);
    bus.verify_en = ver;
    if (expect_run) begin
      npass    = ver ? 2 : 1;
      any_zero = 1'b0;
      for (int i = 0; i < PAD_CNT; i++) begin
        e.pads[i] = ref_cfg[i];
        if (ref_cfg[i] != '1) any_zero = 1'b1;
      end
      e.busy_cyc = npass * TOTAL * 2 * (d + 1) + (d + 1) + 1;
      e.rises    = npass * TOTAL;
      e.load_cyc = d + 1;
      e.chk_err  = ver && fault_en && any_zero;
      e.chk_pads = !fault_en;
      exp_q.push_back(e);
    end
    @(posedge mclk); #2;
    bus.start = 1'b0;
    if (chk_clear) chk("chk_err_cleared_by_start", {63'd0, bus.chk_err}, 64'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < budget) begin
      @(negedge mclk);
      n++;
    end
    chk("update_finished_in_budget", {63'd0, n < budget}, 64'd1);
    @(negedge mclk);
  endtask

  task automatic check_all_rd();
    logic [CFG_BITS-1:0] req;
    for (int a = 0; a < 16; a++) begin
      bus.cfg_rd_addr = 4'(a);
      #1;
      req = (a < PAD_CNT) ? ref_cfg[a] : '0;
      chk($sformatf("rd%0d", a), 64'(bus.cfg_rd_data), 64'(req));
    end
  endtask

  task automatic check_outputs_low(input string tag);
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, bus.done}, 64'd0);
    chk({tag, "_chk_err"}, {63'd0, bus.chk_err}, 64'd0);
    chk({tag, "_sclk"}, {63'd0, bus.serial_clock}, 64'd0);
    chk({tag, "_sload"}, {63'd0, bus.serial_load}, 64'd0);
    chk({tag, "_sdata"}, {63'd0, bus.serial_data}, 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nw, a, d, v;
    bus.cfg_wr_en = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
    bus.cfg_rd_addr = '0; bus.start = 1'b0; bus.verify_en = 1'b0; bus.clk_div = '0;
    for (int i = 0; i < PAD_CNT; i++) ref_cfg[i] = DEF;

    // Reset state, default image, fastest rate.
    repeat (3) @(posedge mclk);
    check_outputs_low("reset");
    #2 reset = 1'b0;
    check_all_rd();
    do_start(0, 1'b0, 1'b1, 1'b0);
    wait_idle(6000);

    // Pad placement of first/last words.
    do_write(0, 16'hA5C3, 1'b0);
    do_write(8, 16'h0001, 1'b0);
    do_start(0, 1'b0, 1'b1, 1'b0);
    wait_idle(6000);

    // Slow clock with a verify pass over an ideal chain.
    do_start(3, 1'b1, 1'b1, 1'b0);
    wait_idle(6000);

    // Stuck-at-1 chain bit with an all-zero image, then a clean run clears the flag.
    for (int i = 0; i < PAD_CNT; i++) do_write(i, 16'h0000, 1'b0);
    fault_en = 1'b1;
    do_start(0, 1'b1, 1'b1, 1'b0);
    wait_idle(6000);
    fault_en = 1'b0;
    do_start(0, 1'b0, 1'b1, 1'b1);
    wait_idle(6000);

    // Writes, a second start and an out-of-range write while busy are all ignored.
    do_write(2, 16'h1234, 1'b0);
    do_start(1, 1'b0, 1'b1, 1'b0);
    repeat (20) @(posedge mclk);
    do_write(3, 16'hDEAD, 1'b1);
    do_start(0, 1'b1, 1'b0, 1'b0);
    do_write(9, 16'hBEEF, 1'b1);
    wait_idle(6000);
    repeat (60) @(negedge mclk);
    chk("no_second_update", {63'd0, bus.busy}, 64'd0);
    do_write(9, 16'hBEEF, 1'b0);
    check_all_rd();

    // Randomized images, rates and verify selection.
    for (int r = 0; r < 5; r++) begin
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        a = $urandom_range(0, 11);
        do_write(a, CFG_BITS'($urandom), 1'b0);
      end
      d = $urandom_range(0, 2);
      v = $urandom_range(0, 1);
      do_start(d, v[0], 1'b1, 1'b0);
      wait_idle(6000);
      check_all_rd();
    end

    // Asynchronous reset in the middle of the shift.
    do_write(5, 16'h5A5A, 1'b0);
    do_start(1, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 2000 && rises < 50; n++) @(negedge mclk);
    chk("reached_bit_50", {63'd0, rises >= 50}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check_outputs_low("mid_reset");
    exp_q.delete();
    for (int i = 0; i < PAD_CNT; i++) ref_cfg[i] = DEF;
    check_all_rd();
    repeat (3) @(posedge mclk);
    #2 reset = 1'b0;
    repeat (10) @(negedge mclk);
    chk("no_load_after_reset", 64'(load_pulses + load_cyc), 64'd0);
    do_start(0, 1'b1, 1'b1, 1'b0);
    wait_idle(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
